pll_lock_seq: RTL and testbench
===============================

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 The block SHALL have parameter LOCK_STABLE, default 1024: the number of consecutive synchronized-locked cycles required before reset release begins (range 2..65535).
REQ-002 The block SHALL have parameter RST_HOLD, default 16: the number of cycles sys_rst stays asserted after the lock is qualified (range 1..255).
REQ-003 The block SHALL have parameter CE_DIV, default 8: the clock-enable division ratio (range 2..255).
REQ-004 clk, input, 1: the 80 MHz system clock, taken from PLL outclk_0.
REQ-005 rst, input, 1: asynchronous, active-high reset.
REQ-006 locked, input, 1: the PLL lock flag; it is asynchronous to clk.
REQ-007 sys_rst, output, 1: synchronous-deassert reset for downstream logic, active-high.
REQ-008 ready, output, 1: high only in state RUN.
REQ-009 ce, output, 1: a single-cycle enable pulse, once every CE_DIV cycles, in RUN only.
REQ-010 state, output, 2: current state encoding, where WAIT_LOCK=0, QUALIFY=1, HOLD=2, RUN=3.
REQ-011 loss_cnt, output, 8: saturating count of lock losses seen in RUN.

Function
REQ-012 locked SHALL pass through a two-flop synchronizer (both flops reset to 0) before any use, giving lk_s; a rise on locked becomes visible in lk_s after the 2nd rising clk edge.
REQ-013 WAIT_LOCK: sys_rst=1, qualify counter = 0; on lk_s=1 go to QUALIFY with counter = 1.
REQ-014 QUALIFY: while lk_s=1 the counter increments by 1 per cycle; when the counter equals LOCK_STABLE, go to HOLD with the hold counter = 0.
REQ-015 QUALIFY: lk_s=0 in any cycle returns the block to WAIT_LOCK and clears the counter, so a glitch restarts qualification from zero; loss_cnt is unchanged.
REQ-016 HOLD: sys_rst=1 and the hold counter increments each cycle; after RST_HOLD cycles in HOLD, go to RUN, and sys_rst falls on the same edge that state becomes 3.
REQ-017 HOLD: lk_s=0 returns the block to WAIT_LOCK; loss_cnt is unchanged.
REQ-018 RUN: sys_rst=0 and ready=1.
REQ-019 RUN: lk_s=0 returns the block to WAIT_LOCK on the next edge, with sys_rst=1 and ready=0 from that edge.
REQ-020 RUN: each lk_s=0 exit SHALL increment loss_cnt by 1, saturating at 255 with no wrap.
REQ-021 The ce divider counter SHALL be cleared to 0 on every entry to RUN and SHALL count 0..CE_DIV-1, wrapping to 0.
REQ-022 ce SHALL be 1 exactly when the divider counter equals CE_DIV-1 and the state is RUN; the first pulse is therefore in the CE_DIV-th RUN cycle.
REQ-023 ce SHALL be 0 in all states other than RUN; it is forced to 0 in the cycle the block leaves RUN.
REQ-024 All outputs SHALL be registered, with no combinational path from locked to any output.
REQ-025 All counters SHALL be sized for their parameter maximum and SHALL never overflow.

Reset
REQ-026 While rst=1, asynchronously: state=WAIT_LOCK, sys_rst=1, ready=0, ce=0, loss_cnt=0, and all counters and synchronizer flops = 0.
REQ-027 Release of rst mid-sequence SHALL restart the block from WAIT_LOCK; no state survives reset.
REQ-028 rst=1 asserted while in RUN SHALL NOT increment loss_cnt.

Verification (bench parameters: LOCK_STABLE=4, RST_HOLD=3, CE_DIV=4)
REQ-029 Cold start: rst released and locked held at 1. Required response: state 0->1 at edge 2, 1->2 at edge 5, and 2->3 at edge 8, with sys_rst falling at edge 8; ce first goes high at edge 11.
REQ-030 Qualify glitch: locked pulled to 0 for 3 cycles at QUALIFY count 3. Required response: return to WAIT_LOCK, count restarts at 1, sys_rst stays 1 throughout, loss_cnt=0.
REQ-031 Lock loss in RUN: locked falls. Required response: 2 cycles later state=0, sys_rst=1, ready=0, ce=0 and loss_cnt=1; relock then repeats the REQ-029 timing.
REQ-032 Saturation: 260 lock losses from RUN. Required response: loss_cnt=255 with no wrap to 0.
REQ-033 Reset mid-HOLD: rst pulsed while in HOLD. Required response: all outputs at their REQ-026 values immediately (asynchronous), and the full sequence restarts after release.
REQ-034 ce spacing in RUN: over 40 cycles, ce pulses are exactly 4 cycles apart and each is 1 cycle wide.

Source files
------------

// File: rtl/pll_lock_seq.sv
// PLL lock sequencer: synchronizes the PLL lock flag, qualifies a stable lock,
// holds downstream reset for a fixed time, then runs with a divided clock enable.
module pll_lock_seq #(
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned CE_DIV      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       sys_rst,
  output logic       ready,
  output logic       ce,
  output logic [1:0] state,
  output logic [7:0] loss_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t      st;
  logic        sync1;
  logic        lk_s;
  logic [15:0] q_cnt;
  logic [7:0]  h_cnt;
  logic [7:0]  div;

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= WAIT_LOCK;
      sync1    <= 1'b0;
      lk_s     <= 1'b0;
      q_cnt    <= '0;
      h_cnt    <= '0;
      div      <= '0;
      sys_rst  <= 1'b1;
      ready    <= 1'b0;
      ce       <= 1'b0;
      loss_cnt <= '0;
    end else begin
      sync1 <= locked;
      lk_s  <= sync1;
      ce    <= 1'b0;
      case (st)
        WAIT_LOCK: begin
          sys_rst <= 1'b1;
          ready   <= 1'b0;
          q_cnt   <= '0;
          h_cnt   <= '0;
          if (lk_s) begin
            st    <= QUALIFY;
            q_cnt <= 16'd1;
          end
        end
        QUALIFY: begin
          if (!lk_s) begin
            st    <= WAIT_LOCK;
            q_cnt <= '0;
          end else if (q_cnt == 16'(LOCK_STABLE - 1)) begin
            // this cycle's sample is the LOCK_STABLE-th consecutive one
            st    <= HOLD;
            q_cnt <= '0;
            h_cnt <= '0;
          end else begin
            q_cnt <= q_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (!lk_s) begin
            st <= WAIT_LOCK;
          end else if (h_cnt == 8'(RST_HOLD - 1)) begin
            st      <= RUN;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
            div     <= '0;
          end else begin
            h_cnt <= h_cnt + 8'd1;
          end
        end
        RUN: begin
          if (!lk_s) begin
            st      <= WAIT_LOCK;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
          end else begin
            div <= (div == 8'(CE_DIV - 1)) ? '0 : div + 8'd1;
            // ce registered one cycle ahead so it coincides with div == CE_DIV-1
            ce  <= (div == 8'(CE_DIV - 2));
          end
        end
        default: st <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq: directed scenarios plus randomized lock
// activity, compared against a streak-length reference model.
module tb_pll_lock_seq;

  localparam int LS = 4;
  localparam int RH = 3;
  localparam int CD = 4;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       sys_rst;
  logic       ready;
  logic       ce;
  logic [1:0] state;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  pll_lock_seq #(.LOCK_STABLE(LS), .RST_HOLD(RH), .CE_DIV(CD)) dut (
    .clk(clk), .rst(rst), .locked(locked), .sys_rst(sys_rst),
    .ready(ready), .ce(ce), .state(state), .loss_cnt(loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: s = number of consecutive synchronized-locked samples.
  // The phase follows from s alone: 0 wait, <LS qualify, <LS+RH hold, else run.
  logic m1 = 1'b0, m2 = 1'b0;
  int   s = 0;
  int   mloss = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= 1'b0; m2 <= 1'b0; s <= 0; mloss <= 0;
    end else begin
      m1 <= locked;
      m2 <= m1;
      if (!m2) begin
        if (s >= LS + RH && mloss < 255) mloss <= mloss + 1;
        s <= 0;
      end else begin
        s <= s + 1;
      end
    end
  end

  function automatic logic [12:0] model_out(input int sv, input int lv);
    logic [1:0] st;
    logic       run;
    logic       c;
    st  = (sv == 0) ? 2'd0 : (sv < LS) ? 2'd1 : (sv < LS + RH) ? 2'd2 : 2'd3;
    run = (sv >= LS + RH);
    c   = run && (((sv - (LS + RH) + 1) % CD) == 0);
    return {st, !run, run, c, 8'(lv)};
  endfunction

  always @(negedge clk)
    if (chk_en) check("model", {state, sys_rst, ready, ce, loss_cnt}, model_out(s, mloss));

  task automatic wait_state(input logic [1:0] want, input int limit);
    int n = 0;
    while (state !== want && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (state !== want) check("wait_timeout", state, want);
  endtask

  // Edges are counted from 0 at the first rising edge after rst release.
  function automatic logic [1:0] cold_state(input int k);
    return (k < 2) ? 2'd0 : (k < 5) ? 2'd1 : (k < 8) ? 2'd2 : 2'd3;
  endfunction

  task automatic cold_start(input string tag);
    rst    = 1'b0;
    locked = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_state"}, state, cold_state(k));
      check({tag, "_sysrst"}, sys_rst, (k < 8) ? 1'b1 : 1'b0);
      check({tag, "_ce"}, ce, (k == 11) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    int pulses;
    int last;
    int bad_sys;
    bit saw_wait;
    rst    = 1'b1;
    locked = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_outs", {state, sys_rst, ready, ce, loss_cnt}, {2'd0, 1'b1, 1'b0, 1'b0, 8'd0});

    cold_start("cold");

    // Lock loss in RUN, then relock with cold-start timing
    locked = 1'b0;
    repeat (3) @(negedge clk);
    check("loss_outs", {state, sys_rst, ready, ce, loss_cnt}, {2'd0, 1'b1, 1'b0, 1'b0, 8'd1});
    rst = 1'b1;
    @(negedge clk);
    check("rst_clears_loss", loss_cnt, 8'd0);
    cold_start("relock");

    // Glitch during QUALIFY at count 3
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    locked = 1'b1;
    repeat (5) @(negedge clk);  // edge 4: qualify count 3
    check("glitch_pre", state, 2'd1);
    locked   = 1'b0;
    saw_wait = 0;
    bad_sys  = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (state == 2'd0) saw_wait = 1;
      if (!sys_rst) bad_sys++;
    end
    locked = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (state == 2'd0) saw_wait = 1;
      if (!sys_rst) bad_sys++;
    end
    check("glitch_wait", saw_wait, 1'b1);
    check("glitch_sysrst", bad_sys, 0);
    check("glitch_loss", loss_cnt, 8'd0);
    wait_state(2'd3, 40);

    // Reset pulsed mid-HOLD
    locked = 1'b0;
    repeat (4) @(negedge clk);
    locked = 1'b1;
    wait_state(2'd2, 40);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", {state, sys_rst, ready, ce, loss_cnt}, {2'd0, 1'b1, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    cold_start("after_hold_rst");

    // ce spacing over 40 RUN cycles
    pulses = 0;
    last   = -1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_state(2'd3, 40);
    for (int i = 1; i <= 40; i++) begin
      if (ce) begin
        if (last >= 0) check("ce_gap", i - last, CD);
        pulses++;
        last = i;
      end
      @(negedge clk);
    end
    check("ce_count", pulses, 10);

    // 260 lock losses from RUN
    for (int i = 0; i < 260; i++) begin
      locked = 1'b1;
      wait_state(2'd3, 40);
      locked = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("loss_sat", loss_cnt, 8'd255);
    locked = 1'b1;
    wait_state(2'd3, 40);
    locked = 1'b0;
    repeat (3) @(negedge clk);
    check("loss_nowrap", loss_cnt, 8'd255);

    // Randomized lock activity with occasional async resets
    for (int i = 0; i < 300; i++) begin
      locked = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        #3 rst = 1'b1;
        #1 check("rand_rst", {state, sys_rst, ready, ce}, {2'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
